// File: rtl/arbiter_pkg.sv
// arbiter_pkg: shared definitions for the Arbiter4 ownership stage.
// Rev 1.0 - initial release.
`default_nettype none

package arbiter_pkg;

  localparam int N_REQ = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    OWN  = ST_OWN,
    GAP  = ST_GAP
  } state_e;

  function automatic logic onehot_ok(input logic [0:N_REQ-1] v);
    int n;
    n = 0;
    for (int i = 0; i < N_REQ; i++) n += int'(v[i]);
    return (n == 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/arbiter4_grant_lock.sv
// arbiter4_grant_lock: registered ownership stage behind Arbiter4 with hold limit,
// post-release idle gap and expiry fairness mask. Rev 1.0 - initial release.
`default_nettype none

module arbiter4_grant_lock
  import arbiter_pkg::*;
#(
  parameter int MAX_HOLD   = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [0:3] req,
  output logic [0:3] arb_r,
  input  logic [0:3] arb_g,
  output logic [0:3] gnt,
  output logic [1:0] owner,
  output logic       busy,
  output logic       err
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0] c_hold_max = HW'(MAX_HOLD);
  localparam logic [GW-1:0] c_gap_last = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e          r_state;
  logic [0:3]      r_gnt;
  logic [0:3]      r_mask;
  logic [1:0]      r_owner;
  logic [HW-1:0]   r_hold_cnt;
  logic [GW-1:0]   r_gap_cnt;
  logic            r_err;

  logic [0:3]      w_masked;
  logic [0:3]      w_owner_bit;
  logic [1:0]      w_gnt_idx;
  logic            w_illegal;
  logic            w_take;
  logic            w_own_req;
  logic            w_expire;

  assign w_masked    = req & ~r_mask;
  assign w_owner_bit = 4'b1000 >> r_owner;
  assign w_own_req   = req[r_owner];
  assign w_expire    = (r_hold_cnt == c_hold_max);

  // The mask only steers arbitration while it leaves someone eligible.
  always_comb begin
    arb_r = '0;
    if (r_state == IDLE) begin
      arb_r = (w_masked != '0) ? w_masked : req;
    end
  end

  assign w_illegal = ((arb_r != '0) && !onehot_ok(arb_g)) || ((arb_g & ~arb_r) != '0);
  assign w_take    = (r_state == IDLE) && (arb_g != '0) && !w_illegal;

  always_comb begin
    w_gnt_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (arb_g[i]) w_gnt_idx = 2'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_mask     <= '0;
      r_owner    <= '0;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_illegal) r_err <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_gnt      <= arb_g;
            r_owner    <= w_gnt_idx;
            r_hold_cnt <= HW'(1);
            r_mask     <= '0;
            r_state    <= OWN;
          end
        end
        OWN: begin
          if (!w_own_req || w_expire) begin
            r_gnt      <= '0;
            r_hold_cnt <= '0;
            r_gap_cnt  <= '0;
            // Still requesting means the limit forced this release.
            if (w_own_req) r_mask <= w_owner_bit;
            r_state    <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        GAP: begin
          if (r_gap_cnt == c_gap_last) begin
            r_gap_cnt <= '0;
            r_state   <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign owner = r_owner;
  assign busy  = |r_gnt;
  assign err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_arbiter4_grant_lock.sv
// tb_arbiter4_grant_lock: scoreboard bench with a behavioural Arbiter4 and ownership model.
// Rev 1.0 - initial release.
`default_nettype none

module tb_arbiter4_grant_lock;

  localparam int MAX_HOLD   = 4;
  localparam int GAP_CYCLES = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [0:3] req = '0;
  logic [0:3] arb_r;
  logic [0:3] arb_g;
  logic [0:3] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       err;
  logic       force_en = 1'b0;
  logic [0:3] force_val = '0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [0:3] arb_r;
    logic [0:3] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       err;
  } exp_t;

  exp_t expq[$];

  // Reference model: who owns the resource, for how long, and how much cooldown remains.
  int         m_owner;
  int         m_held;
  int         m_gap;
  int         m_last;
  logic [0:3] m_mask;
  logic       m_err;

  always #5 clk = ~clk;

  arbiter4_grant_lock #(.MAX_HOLD(MAX_HOLD), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .reset(reset), .req(req), .arb_r(arb_r), .arb_g(arb_g),
    .gnt(gnt), .owner(owner), .busy(busy), .err(err)
  );

  function automatic logic [0:3] bit_of(input int i);
    logic [0:3] b;
    b = '0;
    b[i] = 1'b1;
    return b;
  endfunction

  function automatic logic [0:3] pick(input logic [0:3] v);
    for (int i = 0; i < 4; i++) if (v[i]) return bit_of(i);
    return '0;
  endfunction

  always_comb arb_g = force_en ? force_val : pick(arb_r);

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("arb_r", arb_r, e.arb_r);
      chk("gnt", gnt, e.gnt);
      chk("owner", {2'b00, owner}, {2'b00, e.owner});
      chk("busy", {3'b000, busy}, {3'b000, e.busy});
      chk("err", {3'b000, err}, {3'b000, e.err});
    end
  end

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_gap = 0; m_last = 0; m_mask = '0; m_err = 1'b0;
  endtask

  task automatic step(input logic [0:3] r, input logic fe = 1'b0, input logic [0:3] fv = 4'b0000);
    exp_t e;
    logic [0:3] ar, g, elig;
    logic illegal;
    @(posedge clk); #1;
    req = r; force_en = fe; force_val = fv;
    ar = '0;
    if (m_owner < 0 && m_gap == 0) begin
      elig = r & ~m_mask;
      ar = (elig != '0) ? elig : r;
    end
    e.arb_r = ar;
    e.gnt   = (m_owner >= 0) ? bit_of(m_owner) : 4'b0000;
    e.owner = 2'(m_last);
    e.busy  = (m_owner >= 0);
    e.err   = m_err;
    expq.push_back(e);
    g = fe ? fv : pick(ar);
    illegal = ((ar != '0) && ($countones(g) != 1)) || ((g & ~ar) != '0);
    if (illegal) m_err = 1'b1;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1; m_gap = GAP_CYCLES;
      end else if (m_held == MAX_HOLD) begin
        m_mask = bit_of(m_owner); m_owner = -1; m_gap = GAP_CYCLES;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (!illegal && g != '0) begin
      for (int i = 0; i < 4; i++) if (g[i]) m_owner = i;
      m_last = m_owner; m_held = 1; m_mask = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("async_gnt", gnt, 4'b0000);
    chk("async_busy", {3'b000, busy}, 4'b0000);
    model_reset();
    req = '0; force_en = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b0;
  endtask

  initial begin
    logic [0:3] r;
    model_reset();
    #23 reset = 1'b0;

    repeat (4) step(4'b0110);
    repeat (5) step(4'b0010);
    repeat (4) step(4'b0000);
    repeat (16) step(4'b1100);
    repeat (4) step(4'b0000);
    repeat (12) step(4'b1000);
    repeat (4) step(4'b0000);
    step(4'b1100, 1'b1, 4'b1100);
    repeat (3) step(4'b0000);
    do_reset();
    repeat (2) step(4'b0010);
    do_reset();
    repeat (3) step(4'b0001);

    r = req;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (m_owner == i) begin
          if ($urandom_range(0, 3) == 0) r[i] = 1'b0;
        end else if (!r[i] && $urandom_range(0, 2) == 0) begin
          r[i] = 1'b1;
        end
      end
      step(r);
    end

    @(negedge clk); #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: actual %0d pending expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/arbiter4_grant_lock.md
# arbiter4_grant_lock

Registered ownership stage placed directly downstream of the 4-bit daisy-chain arbiter (`Arbiter4`). It forwards client requests to the arbiter, captures the arbiter's one-hot grant into a registered grant, and holds ownership until the owner drops its request or a hold limit expires. A configurable idle gap follows each release. Hold-expiry fairness masking keeps one requester from monopolising the chain. Bit 0 is highest priority, matching the arbiter's `[0:3]` ordering.

## Interface
- `MAX_HOLD`, 16, maximum consecutive cycles one owner may hold `gnt` (≥1)
- `GAP_CYCLES`, 1, forced idle cycles after every release (≥0)
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset; the polarity and synchronicity are fixed
- `req`  in  [0:3]  level requests from clients; a client holds `req` high until it is granted, and while it owns the resource
- `arb_r`  out  [0:3]  requests driven into `Arbiter4` (combinational)
- `arb_g`  in  [0:3]  combinational grant returned by `Arbiter4`
- `gnt`  out  [0:3]  registered one-hot ownership grant
- `owner`  out  2  index of the current owner; valid while `busy`
- `busy`  out  1  high while any `gnt` bit is set
- `err`  out  1  sticky; set when `arb_g` is not one-hot while `arb_r` is non-zero, or when `arb_g` has a bit set that is not in `arb_r`

## Operation
- States: IDLE, OWN, GAP.
- IDLE:
  - `arb_r = req & ~mask`; if that value is 0, `arb_r = req`.
  - If `arb_g` is non-zero and legal: register `gnt <= arb_g`, `owner <=` its index, `hold_cnt <= 1`, go to OWN, clear `mask`.
- OWN:
  - `arb_r = 0`. Other requests are ignored and must stay asserted.
  - `hold_cnt` increments every cycle.
  - Release when `req[owner]==0` or `hold_cnt==MAX_HOLD`: `gnt <= 0`.
  - Next state is GAP if `GAP_CYCLES>0`, else IDLE.
- Expiry release (`req[owner]` still high when `hold_cnt==MAX_HOLD`): `mask <= onehot(owner)`.
- Drop release, or drop and expiry in the same cycle: `mask` is left unchanged.
- GAP:
  - `arb_r = 0`, `gnt = 0`.
  - Counts `GAP_CYCLES` cycles, then goes to IDLE.
- An illegal `arb_g` in IDLE sets `err`. No grant is taken, and the block stays in IDLE.
- `err` clears only on `reset`.

## Timing
- Reset values: `gnt=0`, `owner=0`, `busy=0`, `err=0`, `mask=0`, state IDLE, counters 0.
- Reset asserted mid-operation: `gnt` and `busy` drop asynchronously.
- Grant latency: `req` seen in IDLE at edge n → `gnt` valid after edge n, i.e. 1 cycle.
- `arb_r` is combinational from `req` and state. The `Arbiter4` path is combinational, so the loop `req→arb_r→arb_g→gnt D-input` is a single cycle.
- Hold length:
  - `gnt` stays high at most `MAX_HOLD` cycles.
  - An owner dropping `req` before edge k has `gnt` low after edge k.
- Minimum spacing between grants: 1 + `GAP_CYCLES` cycles with `gnt=0`. With `GAP_CYCLES=0` it is 1 IDLE cycle.
- `hold_cnt` width is `$clog2(MAX_HOLD+1)`; it never wraps because release occurs at `MAX_HOLD`.
- `busy == |gnt` at all times. `owner` holds its last value when not busy.

## Structure
- Shared package `arbiter_pkg`: `N_REQ=4`, state enum (`IDLE`,`OWN`,`GAP`), `onehot_ok` function.
- Single module. `Arbiter4` is instantiated by the parent and connected via `arb_r`/`arb_g`. No sub-module.

## Test plan
- Reset then `req=4'b0110` → `arb_r=0110`, `gnt=0100` one cycle later, `owner=1`, `busy=1`.
- Owner 1 drops `req` after 3 cycles while `req[2]` is held, `GAP_CYCLES=1` → `gnt=0000` for 2 cycles, then `gnt=0010`.
- `MAX_HOLD=4`, `req=1100` held constant → `gnt=1000` for exactly 4 cycles, then gap. Next grant is `0100` (bit 0 masked). After that release, bit 0 is regranted.
- `MAX_HOLD=4`, only `req=1000` held → expiry, gap, then `gnt=1000` again, because the mask is ignored when it zeroes `arb_r`.
- Force `arb_g=1100` in IDLE with `req=1100` → `err=1` sticky, `gnt` stays 0000. Reset clears `err`.
- Assert `reset` mid-OWN with `gnt=0010` → `gnt=0000` and `busy=0` immediately, without waiting for a clock edge. After deassert, `req=0001` → `gnt=0001` after 1 edge.
